branch_ctrl: RTL and testbench

//  Sequences conditional-branch resolution in the EX stage. Accepts one branch per handshake and latches its

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/branch_cmp.sv | 36 +++
 rtl/branch_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_branch_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Purpose: shared RISC-V constants for the EX-stage branch logic.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 010 and 011 are the only unused encodings in the branch major opcode.
    function automatic logic f3_is_branch(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Purpose: evaluates a conditional-branch condition from funct3 and two operands.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   funct3  branch type select
//   a, b    rs1 / rs2 operand values
//   cond    branch condition holds (0 when funct3 is illegal)
//   legal   funct3 is a defined branch type
module branch_cmp
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            cond,
    output logic            legal
);

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            F3_BEQ:  cond = (a == b);
            F3_BNE:  cond = (a != b);
            F3_BLT:  cond = ($signed(a) <  $signed(b));
            F3_BGE:  cond = ($signed(a) >= $signed(b));
            F3_BLTU: cond = (a <  b);
            F3_BGEU: cond = (a >= b);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Purpose: EX-stage branch sequencer: latch, evaluate, redirect fetch, flush IF/ID.
// Latency: accept T, evaluate T+1, redir_valid/bad_br at T+2; flush FLUSH_CYCLES cycles after redir_ack.
// Backpressure: br_ready only in IDLE (stall = ~br_ready); redirect held until redir_ack.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   br_valid/br_ready             branch handshake; opcode, funct3, rs1_val, rs2_val, br_pc, br_imm captured on it
//   kill                          abort to IDLE next cycle (only rst is stronger)
//   redir_valid/redir_ack         PC redirect to fetch, redir_target stable while valid
//   flush, stall                  IF/ID squash and hold
//   bad_br                        1-cycle pulse for illegal branch or misaligned taken target
//   taken_cnt, ntaken_cnt         saturating resolution statistics
module branch_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN         = riscv_pkg::XLEN,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_imm,
    input  logic             kill,
    output logic             redir_valid,
    output logic [XLEN-1:0]  redir_target,
    input  logic             redir_ack,
    output logic             flush,
    output logic             stall,
    output logic             bad_br,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_REDIR = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
    } br_req_t;

    state_e          state_q, state_d;
    br_req_t         req_q;
    logic [FCW-1:0]  fcnt_q, fcnt_d;

    logic            cond, legal;
    logic [XLEN-1:0] target;
    logic            illegal;
    logic            misaligned;

    logic            redir_valid_d, flush_d, bad_br_d;
    logic            taken_inc, ntaken_inc, target_ld;
    logic            capture;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3 (req_q.funct3),
        .a      (req_q.rs1),
        .b      (req_q.rs2),
        .cond   (cond),
        .legal  (legal)
    );

    // Wraps mod 2^XLEN by construction of the adder width.
    assign target     = req_q.pc + req_q.imm;
    assign illegal    = (req_q.opcode != OPC_BRANCH) || !legal || !f3_is_branch(req_q.funct3);
    assign misaligned = (target[1:0] != 2'b00);

    assign br_ready = (state_q == ST_IDLE);
    assign stall    = ~br_ready;
    assign capture  = br_ready && br_valid && !kill;

    // ---------------- state register (plus registered outputs) ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            fcnt_q       <= '0;
            redir_valid  <= 1'b0;
            redir_target <= '0;
            flush        <= 1'b0;
            bad_br       <= 1'b0;
            taken_cnt    <= '0;
            ntaken_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            redir_valid <= redir_valid_d;
            flush       <= flush_d;
            bad_br      <= bad_br_d;
            if (capture) begin
                req_q.opcode <= opcode;
                req_q.funct3 <= funct3;
                req_q.rs1    <= rs1_val;
                req_q.rs2    <= rs2_val;
                req_q.pc     <= br_pc;
                req_q.imm    <= br_imm;
            end
            if (target_ld) begin
                redir_target <= target;
            end
            if (taken_inc && (taken_cnt != {CNT_W{1'b1}})) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
            if (ntaken_inc && (ntaken_cnt != {CNT_W{1'b1}})) begin
                ntaken_cnt <= ntaken_cnt + CNT_W'(1);
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (br_valid) state_d = ST_EVAL;
                ST_EVAL: begin
                    if (!illegal && cond && !misaligned) state_d = ST_REDIR;
                    else                                  state_d = ST_IDLE;
                end
                ST_REDIR: if (redir_ack) state_d = ST_FLUSH;
                ST_FLUSH: if (fcnt_q == '0) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- output / datapath control logic ----------------
    // Computes the values the registered outputs take at the next edge, so
    // redir_valid and flush line up exactly with the REDIR / FLUSH states.
    always_comb begin
        redir_valid_d = (state_d == ST_REDIR);
        flush_d       = (state_d == ST_FLUSH);
        bad_br_d      = 1'b0;
        taken_inc     = 1'b0;
        ntaken_inc    = 1'b0;
        target_ld     = 1'b0;
        fcnt_d        = fcnt_q;

        if (!kill) begin
            case (state_q)
                ST_EVAL: begin
                    if (illegal) begin
                        bad_br_d = 1'b1;
                    end else if (!cond) begin
                        ntaken_inc = 1'b1;
                    end else if (misaligned) begin
                        bad_br_d = 1'b1;
                    end else begin
                        taken_inc = 1'b1;
                        target_ld = 1'b1;
                    end
                end
                ST_REDIR: begin
                    // Down-counter reaches zero on the last flush cycle.
                    if (redir_ack) fcnt_d = FCW'(FLUSH_CYCLES - 1);
                end
                ST_FLUSH: begin
                    if (fcnt_q != '0) fcnt_d = fcnt_q - FCW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             br_valid;
    logic             br_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  rs1_val, rs2_val, br_pc, br_imm;
    logic             kill;
    logic             redir_valid;
    logic [XLEN-1:0]  redir_target;
    logic             redir_ack;
    logic             flush;
    logic             stall;
    logic             bad_br;
    logic [CNT_W-1:0] taken_cnt, ntaken_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .br_valid     (br_valid),
        .br_ready     (br_ready),
        .opcode       (opcode),
        .funct3       (funct3),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .br_pc        (br_pc),
        .br_imm       (br_imm),
        .kill         (kill),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .redir_ack    (redir_ack),
        .flush        (flush),
        .stall        (stall),
        .bad_br       (bad_br),
        .taken_cnt    (taken_cnt),
        .ntaken_cnt   (ntaken_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a branch for one cycle (cycle T); returns in cycle T+1.
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm);
        br_valid = 1'b1; opcode = opc; funct3 = f3;
        rs1_val = a; rs2_val = b; br_pc = pc; br_imm = imm;
        step();
        br_valid = 1'b0;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_ready"}, 64'(br_ready), 64'd1);
        chk({tag, "_stall"}, 64'(stall), 64'd0);
        chk({tag, "_rv"},    64'(redir_valid), 64'd0);
        chk({tag, "_flush"}, 64'(flush), 64'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; br_valid = 1'b0; opcode = '0; funct3 = '0;
        rs1_val = '0; rs2_val = '0; br_pc = '0; br_imm = '0;
        kill = 1'b0; redir_ack = 1'b0;
        step(); step();
        rst = 1'b0;

        // ---- reset state ----
        chk_idle_outs("rst");
        chk("rst_tgt",  64'(redir_target), 64'd0);
        chk("rst_bad",  64'(bad_br), 64'd0);
        chk("rst_tc",   64'(taken_cnt), 64'd0);
        chk("rst_ntc",  64'(ntaken_cnt), 64'd0);

        // ---- 1: BEQ taken, full redirect/flush sequence ----
        issue(7'b1100011, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20);   // now T+1
        chk("t1_eval_ready", 64'(br_ready), 64'd0);
        chk("t1_eval_stall", 64'(stall), 64'd1);
        chk("t1_eval_rv",    64'(redir_valid), 64'd0);
        step();                                                       // T+2
        chk("t1_rv",  64'(redir_valid), 64'd1);
        chk("t1_tgt", 64'(redir_target), 64'h120);
        chk("t1_tc",  64'(taken_cnt), 64'd1);
        redir_ack = 1'b1;
        step();                                                       // T+3
        redir_ack = 1'b0;
        chk("t1_fl1",   64'(flush), 64'd1);
        chk("t1_fl1rv", 64'(redir_valid), 64'd0);
        step();                                                       // T+4
        chk("t1_fl2", 64'(flush), 64'd1);
        step();                                                       // T+5
        chk_idle_outs("t1_done");

        // ---- 2: BLT signed taken, BLTU same operands not taken ----
        issue(7'b1100011, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h400, 32'h8);
        step();
        chk("t2_blt_rv",  64'(redir_valid), 64'd1);
        chk("t2_blt_tgt", 64'(redir_target), 64'h408);
        redir_ack = 1'b1; step(); redir_ack = 1'b0;
        step(); step();
        chk_idle_outs("t2_blt_done");
        chk("t2_blt_tc", 64'(taken_cnt), 64'd2);
        issue(7'b1100011, 3'b110, 32'hFFFFFFFF, 32'd1, 32'h400, 32'h8);
        chk("t2_bltu_busy", 64'(br_ready), 64'd0);
        step();                                                       // T+2
        chk_idle_outs("t2_bltu");
        chk("t2_bltu_ntc", 64'(ntaken_cnt), 64'd1);
        chk("t2_bltu_tc",  64'(taken_cnt), 64'd2);
        chk("t2_bltu_bad", 64'(bad_br), 64'd0);

        // ---- 3: illegal funct3, non-branch opcode, misaligned taken target ----
        issue(7'b1100011, 3'b010, 32'd1, 32'd1, 32'h100, 32'h20);
        step();
        chk("t3_f3_bad", 64'(bad_br), 64'd1);
        chk_idle_outs("t3_f3");
        step();
        chk("t3_f3_bad_end", 64'(bad_br), 64'd0);
        chk("t3_f3_tc",  64'(taken_cnt), 64'd2);
        chk("t3_f3_ntc", 64'(ntaken_cnt), 64'd1);
        issue(7'b0110011, 3'b000, 32'd1, 32'd1, 32'h100, 32'h20);
        step();
        chk("t3_opc_bad", 64'(bad_br), 64'd1);
        chk("t3_opc_rv",  64'(redir_valid), 64'd0);
        step();
        issue(7'b1100011, 3'b001, 32'd1, 32'd2, 32'h100, 32'h2);
        step();
        chk("t3_mis_bad", 64'(bad_br), 64'd1);
        chk("t3_mis_rv",  64'(redir_valid), 64'd0);
        step();
        chk("t3_mis_bad_end", 64'(bad_br), 64'd0);
        chk("t3_tc",  64'(taken_cnt), 64'd2);
        chk("t3_ntc", 64'(ntaken_cnt), 64'd1);

        // ---- 4: redirect held 5 cycles without ack, br_valid ignored ----
        issue(7'b1100011, 3'b101, 32'd5, 32'd3, 32'h200, 32'h40);
        step();
        for (int i = 0; i < 5; i++) begin
            br_valid = i[0]; opcode = 7'b1100011; funct3 = 3'b000;
            rs1_val = 32'd7; rs2_val = 32'd7; br_pc = 32'h800; br_imm = 32'h100;
            chk("t4_rv",    64'(redir_valid), 64'd1);
            chk("t4_tgt",   64'(redir_target), 64'h240);
            chk("t4_stall", 64'(stall), 64'd1);
            step();
        end
        br_valid = 1'b0;
        chk("t4_rv_last", 64'(redir_valid), 64'd1);
        redir_ack = 1'b1; step(); redir_ack = 1'b0;
        chk("t4_fl1", 64'(flush), 64'd1);
        step();
        chk("t4_fl2", 64'(flush), 64'd1);
        step();
        chk_idle_outs("t4_done");
        chk("t4_tc", 64'(taken_cnt), 64'd3);
        step();
        chk("t4_nocap", 64'(br_ready), 64'd1);
        chk("t4_nocap_tc", 64'(taken_cnt), 64'd3);

        // ---- 5: kill in REDIR with same-cycle ack; kill in EVAL ----
        issue(7'b1100011, 3'b111, 32'd3, 32'd3, 32'h300, 32'hFFFFFFFC);
        step();
        chk("t5_rv",  64'(redir_valid), 64'd1);
        chk("t5_tgt", 64'(redir_target), 64'h2FC);
        kill = 1'b1; redir_ack = 1'b1;
        step();
        kill = 1'b0; redir_ack = 1'b0;
        chk_idle_outs("t5_kill");
        step();
        chk("t5_nofl", 64'(flush), 64'd0);
        chk("t5_tc",   64'(taken_cnt), 64'd4);
        issue(7'b1100011, 3'b000, 32'd9, 32'd9, 32'h500, 32'h10);
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk_idle_outs("t5_evkill");
        chk("t5_evkill_bad", 64'(bad_br), 64'd0);
        step();
        chk("t5_evkill_rv",  64'(redir_valid), 64'd0);
        chk("t5_evkill_tc",  64'(taken_cnt), 64'd4);
        chk("t5_evkill_ntc", 64'(ntaken_cnt), 64'd1);

        // ---- 6: PC wrap, then rst during FLUSH ----
        issue(7'b1100011, 3'b000, 32'd1, 32'd1, 32'hFFFFFFF0, 32'h20);
        step();
        chk("t6_rv",  64'(redir_valid), 64'd1);
        chk("t6_tgt", 64'(redir_target), 64'h10);
        redir_ack = 1'b1; step(); redir_ack = 1'b0;
        chk("t6_fl", 64'(flush), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle_outs("t6_rst");
        chk("t6_rst_tgt", 64'(redir_target), 64'd0);
        chk("t6_rst_tc",  64'(taken_cnt), 64'd0);
        chk("t6_rst_ntc", 64'(ntaken_cnt), 64'd0);
        chk("t6_rst_bad", 64'(bad_br), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
